// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and multiplier FSM states for the pipelined ALU.
// The multiplier is present only when ALU_MUL_EN is defined.
package alu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd6;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd8;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd9;

  // flags vector is {N,Z,C,V}
  localparam int unsigned FLG_V = 0;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_N = 3;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// Handshake bundle between decoder (operand source), ALU and writeback (result sink).
interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   instruction;
  logic [WIDTH-1:0]  inputA;
  logic [WIDTH-1:0]  inputB;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  alu_out;
  logic [FLAG_W-1:0] flags;
  logic              err;

  modport master (
    output in_valid, instruction, inputA, inputB, out_ready,
    input  in_ready, out_valid, alu_out, flags, err
  );

  modport slave (
    input  in_valid, instruction, inputA, inputB, out_ready,
    output in_ready, out_valid, alu_out, flags, err
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier, one partial product per cycle, low WIDTH bits kept.
// Compiled only when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             ack_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  mul_state_e        state_q, state_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // DONE holds the product until the pipeline takes it into the output stage
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      MUL_IDLE: begin
        if (start_i) begin
          mcand_d  = a_i;
          mplier_d = b_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MUL_DONE;
      end
      MUL_DONE: begin
        if (ack_i) state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  assign busy_o    = (state_q == MUL_BUSY);
  assign done_o    = (state_q == MUL_DONE);
  assign product_o = acc_q;

endmodule
`endif

// File: rtl/alu_pipe.sv
// Two-stage handshaked ALU: s1 captures operands, s2 holds result/flags/err for the sink.
// Define ALU_MUL_EN to execute opcode 8 on the sequential multiplier; otherwise it is illegal.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  alu_pipe_if.slave  bus
);
  localparam int unsigned SH_W = $clog2(WIDTH);
  localparam int unsigned MSB  = WIDTH - 1;

  logic              s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]   s1_op_q, s1_op_d;
  logic [WIDTH-1:0]  s1_a_q, s1_a_d;
  logic [WIDTH-1:0]  s1_b_q, s1_b_d;
  logic              s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]  s2_res_q, s2_res_d;
  logic [FLAG_W-1:0] s2_flg_q, s2_flg_d;
  logic              s2_err_q, s2_err_d;

  logic              in_ready_c;
  logic              accept_c;
  logic              out_fire_c;
  logic              s1_move_c;
  logic              mul_lock_c;
  logic              mul_hold_c;

  logic [WIDTH:0]    sum_c;
  logic [WIDTH-1:0]  ex_res_c;
  logic [FLAG_W-1:0] ex_flg_c;
  logic              ex_err_c;
  logic              ex_carry_c;
  logic              ex_ovf_c;

`ifdef ALU_MUL_EN
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  // Multiplier starts on the accept edge so its result is ready WIDTH edges later
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (accept_c && (bus.instruction == OP_MUL)),
    .ack_i     (s1_move_c),
    .a_i       (bus.inputA),
    .b_i       (bus.inputB),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  assign mul_lock_c = mul_busy || mul_done;
  assign mul_hold_c = (s1_op_q == OP_MUL) && !mul_done;
`else
  assign mul_lock_c = 1'b0;
  assign mul_hold_c = 1'b0;
`endif

  assign out_fire_c = s2_valid_q && bus.out_ready;
  assign s1_move_c  = s1_valid_q && (!s2_valid_q || bus.out_ready) && !mul_hold_c;
  assign in_ready_c = !mul_lock_c && (!s1_valid_q || s1_move_c);
  assign accept_c   = bus.in_valid && in_ready_c;

  // Execute on the s1 contents
  always_comb begin
    sum_c      = '0;
    ex_res_c   = '0;
    ex_err_c   = 1'b0;
    ex_carry_c = 1'b0;
    ex_ovf_c   = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        sum_c      = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        ex_res_c   = sum_c[WIDTH-1:0];
        ex_carry_c = sum_c[WIDTH];
        ex_ovf_c   = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum_c[MSB] != s1_a_q[MSB]);
      end
      OP_SUB: begin
        sum_c      = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        ex_res_c   = sum_c[WIDTH-1:0];
        ex_carry_c = sum_c[WIDTH];
        ex_ovf_c   = (s1_a_q[MSB] != s1_b_q[MSB]) && (sum_c[MSB] != s1_a_q[MSB]);
      end
      OP_AND:  ex_res_c = s1_a_q & s1_b_q;
      OP_OR:   ex_res_c = s1_a_q | s1_b_q;
      OP_XOR:  ex_res_c = s1_a_q ^ s1_b_q;
      OP_NOT:  ex_res_c = ~s1_a_q;
      OP_SHL:  ex_res_c = s1_a_q << s1_b_q[SH_W-1:0];
      OP_SHR:  ex_res_c = s1_a_q >> s1_b_q[SH_W-1:0];
`ifdef ALU_MUL_EN
      OP_MUL:  ex_res_c = mul_prod;
`endif
      OP_SLTU: ex_res_c = {{(WIDTH-1){1'b0}}, (s1_a_q < s1_b_q)};
      default: ex_err_c = 1'b1;
    endcase

    ex_flg_c = '0;
    if (!ex_err_c) begin
      ex_flg_c[FLG_N] = ex_res_c[MSB];
      ex_flg_c[FLG_Z] = (ex_res_c == '0);
      ex_flg_c[FLG_C] = ex_carry_c;
      ex_flg_c[FLG_V] = ex_ovf_c;
    end
  end

  // Stage next-state: accept into s1, move s1 into s2, retire s2 on transfer
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_flg_d   = s2_flg_q;
    s2_err_d   = s2_err_q;

    if (s1_move_c) s1_valid_d = 1'b0;
    if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_op_d    = bus.instruction;
      s1_a_d     = bus.inputA;
      s1_b_d     = bus.inputB;
    end

    if (out_fire_c) s2_valid_d = 1'b0;
    if (s1_move_c) begin
      s2_valid_d = 1'b1;
      s2_res_d   = ex_res_c;
      s2_flg_d   = ex_flg_c;
      s2_err_d   = ex_err_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_flg_q   <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_flg_q   <= s2_flg_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = s2_valid_q;
  assign bus.alu_out   = s2_res_q;
  assign bus.flags     = s2_flg_q;
  assign bus.err       = s2_err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8); build with or without ALU_MUL_EN.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int unsigned W = 8;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    logic       err;
    int         acc;
    bit         lchk;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   lchk  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s (t=%0t)", name, msg, $time);
  endtask

  // Reference ALU in plain integer arithmetic
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a8, input logic [7:0] b8);
    exp_t e;
    int a, b, sa, sb, s, r;
    bit c, v, ill;
    a = int'(a8); b = int'(b8);
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r = 0; s = 0; c = 1'b0; v = 1'b0; ill = 1'b0;
    case (op)
      4'd0: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      4'd1: begin r = a - b; c = (a < b);   s = sa - sb; v = (s > 127) || (s < -128); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = 255 - a;
      4'd6: r = a << (b % 8);
      4'd7: r = a >> (b % 8);
      4'd8: if (MUL_EN) r = a * b; else ill = 1'b1;
      4'd9: r = (a < b) ? 1 : 0;
      default: ill = 1'b1;
    endcase
    r = r & 255;
    e.res  = ill ? 8'h00 : r[7:0];
    e.flg  = ill ? 4'h0 : {(r >= 128), (r == 0), c, v};
    e.err  = ill;
    e.acc  = 0;
    e.lchk = 1'b0;
    e.lat  = (op == 4'd8 && MUL_EN) ? 10 : 2;
    return e;
  endfunction

  function automatic logic [31:0] pack(input exp_t e);
    return 32'({e.res, e.flg, e.err});
  endfunction

  // Compare every delivered result against the model queue; held outputs must not move
  logic [13:0] prev;
  bit          hold_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        chk("hold_stable", 32'({bus.out_valid, bus.alu_out, bus.flags, bus.err}), 32'(prev));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("result", 32'({bus.alu_out, bus.flags, bus.err}), pack(e));
          if (e.lchk) chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev      = {bus.out_valid, bus.alu_out, bus.flags, bus.err};
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    bit   ok;
    int   g;
    e = model(op, a, b);
    bus.in_valid = 1'b1; bus.instruction = op; bus.inputA = a; bus.inputB = b;
    ok = 1'b0; g = 0;
    while (!ok && g < 60) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
      g++;
    end
    bus.in_valid = 1'b0;
    if (ok) begin
      e.acc  = cyc;
      e.lchk = lchk;
      q.push_back(e);
    end else begin
      fail("accept_timeout", "in_ready never asserted");
    end
  endtask

  task automatic wait_out(input string name, input logic [7:0] r, input logic [3:0] f,
                          input logic e, input int exp_g);
    int g;
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.out_valid && g < 40);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_edges"}, 32'(g), 32'(exp_g));
    chk({name, "_res"},   32'(bus.alu_out), 32'(r));
    chk({name, "_flags"}, 32'(bus.flags), 32'(f));
    chk({name, "_err"},   32'(bus.err), 32'(e));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int g;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.instruction = '0; bus.inputA = '0; bus.inputB = '0;
    bus.out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu_out",   32'(bus.alu_out),   32'd0);
    chk("rst_flags",     32'(bus.flags),     32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // Hand-computed values pinning the model
    chk("model_add",  pack(model(OP_ADD,  8'h7F, 8'h01)), 32'({8'h80, 4'b1001, 1'b0}));
    chk("model_sub",  pack(model(OP_SUB,  8'h00, 8'h01)), 32'({8'hFF, 4'b1010, 1'b0}));
    chk("model_shl",  pack(model(OP_SHL,  8'h81, 8'h01)), 32'({8'h02, 4'b0000, 1'b0}));
    chk("model_sltu", pack(model(OP_SLTU, 8'h03, 8'h05)), 32'({8'h01, 4'b0000, 1'b0}));
    chk("model_ill",  pack(model(4'hF,    8'h12, 8'h34)), 32'({8'h00, 4'b0000, 1'b1}));
    chk("model_mul",  pack(model(OP_MUL,  8'h0C, 8'h0B)),
        MUL_EN ? 32'({8'h84, 4'b1000, 1'b0}) : 32'({8'h00, 4'b0000, 1'b1}));

    @(posedge clk); #1;
    reset = 1'b1;
    lchk  = 1'b1;

    send(OP_ADD, 8'h7F, 8'h01);
    wait_out("add_ovf", 8'h80, 4'b1001, 1'b0, 2);
    send(OP_SUB, 8'h00, 8'h01);
    wait_out("sub_borrow", 8'hFF, 4'b1010, 1'b0, 2);

    send(OP_AND, 8'hF0, 8'h3C);
    send(OP_OR,  8'hF0, 8'h0C);
    send(OP_XOR, 8'hFF, 8'h0F);
    send(OP_NOT, 8'hFF, 8'h00);
    send(OP_SHR, 8'h80, 8'h0F);
    repeat (4) @(posedge clk);
    #1;

    send(4'hF, 8'h55, 8'hAA);
    wait_out("illegal", 8'h00, 4'b0000, 1'b1, 2);
    send(OP_SHL, 8'h81, 8'h01);
    wait_out("shl", 8'h02, 4'b0000, 1'b0, 2);
    send(OP_SLTU, 8'h03, 8'h05);
    wait_out("sltu", 8'h01, 4'b0000, 1'b0, 2);

    send(OP_MUL, 8'h0C, 8'h0B);
    @(negedge clk);
    chk("mul_in_ready", 32'(bus.in_ready), MUL_EN ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    wait_out("mul", MUL_EN ? 8'h84 : 8'h00, MUL_EN ? 4'b1000 : 4'b0000,
             MUL_EN ? 1'b0 : 1'b1, MUL_EN ? 9 : 1);
    send(OP_ADD, 8'hFF, 8'h01);
    wait_out("add_after_mul", 8'h00, 4'b0110, 1'b0, 2);

    // Backpressure: two ops fill s2 and s1, third waits for release
    lchk = 1'b0;
    bus.out_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h02);
    send(OP_SUB, 8'h10, 8'h01);
    @(negedge clk);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_res", 32'(bus.alu_out), 32'h03);
    @(posedge clk); #1;
    fork
      send(OP_OR, 8'hF0, 8'h0F);
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Reset while the multiplier (or a stalled op) is in flight
    bus.out_ready = 1'b0;
    send(OP_ADD, 8'h10, 8'h20);
    send(OP_MUL, 8'h03, 8'h04);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_alu_out",   32'(bus.alu_out),   32'd0);
    chk("mid_rst_flags",     32'(bus.flags),     32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    lchk = 1'b1;
    send(OP_ADD, 8'h05, 8'h03);
    wait_out("post_rst_add", 8'h08, 4'b0000, 1'b0, 2);
    send(OP_MUL, 8'h0C, 8'h0B);
    repeat (14) @(posedge clk);
    #1;

    g = 0;
    while (q.size() != 0 && g < 40) begin @(posedge clk); g++; end
    if (q.size() != 0) fail("drain", "expected results never delivered");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
